// File: rtl/div_unit_pkg.sv
// Shared processor package: divider state encoding, iteration count and helpers.
package div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } div_state_t;

    localparam int DIV_ITERS = 32;
    localparam int COUNT_W   = $clog2(DIV_ITERS);

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// 32-bit signed restoring divider: one quotient bit per clock, sign fix-up on FINISH.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    div_state_t         state;
    div_state_t         state_next;
    logic [COUNT_W-1:0] count;
    logic [32:0]        rem;
    logic [31:0]        quot;
    logic [31:0]        divisor;
    logic               neg_rem;
    logic               neg_quot;
    logic [32:0]        rem_shift;
    logic [32:0]        trial;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && (b != 32'd0)) state_next = RUN;
            RUN:     if (count == COUNT_W'(DIV_ITERS - 1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The dividend register doubles as the quotient: its MSB is shifted into the
    // partial remainder while the new quotient bit enters at the LSB.
    always_comb begin
        rem_shift = {rem[31:0], quot[31]};
        trial     = rem_shift - {1'b0, divisor};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            count    <= '0;
            rem      <= '0;
            quot     <= '0;
            divisor  <= '0;
            neg_rem  <= 1'b0;
            neg_quot <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b == 32'd0) begin
                            div_zero <= 1'b1;
                        end else begin
                            quot     <= abs32(a);
                            divisor  <= abs32(b);
                            neg_rem  <= a[31];
                            neg_quot <= a[31] ^ b[31];
                            rem      <= '0;
                            count    <= '0;
                            busy     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (trial[32]) begin
                        rem  <= rem_shift;
                        quot <= {quot[30:0], 1'b0};
                    end else begin
                        rem  <= trial;
                        quot <= {quot[30:0], 1'b1};
                    end
                    count <= count + COUNT_W'(1);
                end
                FINISH: begin
                    lo   <= neg_quot ? (~quot + 32'd1) : quot;
                    hi   <= neg_rem ? (~rem[31:0] + 32'd1) : rem[31:0];
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// compared against a 64-bit arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;

    div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 64-bit signed arithmetic truncates toward zero and cannot overflow
    // for 32-bit operands; keeping the low 32 bits gives the wrapping behaviour.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r);
        longint lx;
        longint ly;
        longint lq;
        longint lr;
        lx = longint'($signed(x));
        ly = longint'($signed(y));
        lq = lx / ly;
        lr = lx % ly;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Launch one division at the current negedge and follow it to the done pulse.
    // injectAt >= 0 pulses a spurious start (1/1) that many cycles into the run.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                                 input int injectAt, input string tag);
        logic [31:0] expQ;
        logic [31:0] expR;
        int cycles;
        int busyCnt;
        model(x, y, expQ, expR);
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clk);
        cycles  = 0;
        busyCnt = 0;
        while (!done && cycles < 40) begin
            if (cycles == injectAt) begin
                start = 1'b1;
                a     = 32'd1;
                b     = 32'd1;
            end else begin
                start = 1'b0;
                a     = $urandom;
                b     = $urandom;
            end
            if (busy) busyCnt++;
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput({tag, ".done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, ".latency"}, 32'(cycles), 32'd33);
        checkOutput({tag, ".busy_cycles"}, 32'(busyCnt), 32'd33);
        checkOutput({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, ".lo"}, lo, expQ);
        checkOutput({tag, ".hi"}, hi, expR);
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] ry;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        a           = '0;
        b           = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset.busy", {31'd0, busy}, 32'd0);
        checkOutput("reset.done", {31'd0, done}, 32'd0);
        checkOutput("reset.div_zero", {31'd0, div_zero}, 32'd0);
        checkOutput("reset.hi", hi, 32'd0);
        checkOutput("reset.lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(32'd7, 32'd2, -1, "7/2");
        checkOutput("7/2.lo_const", lo, 32'h00000003);
        checkOutput("7/2.hi_const", hi, 32'h00000001);
        @(negedge clk);
        checkOutput("7/2.done_pulse", {31'd0, done}, 32'd0);

        // Divide by zero: flag for one cycle, no run, results retained.
        start = 1'b1;
        a     = 32'd5;
        b     = 32'd0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("dz.flag", {31'd0, div_zero}, 32'd1);
        checkOutput("dz.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("dz.flag_pulse", {31'd0, div_zero}, 32'd0);
        repeat (5) begin
            checkOutput("dz.no_done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        checkOutput("dz.hi", hi, 32'd1);
        checkOutput("dz.lo", lo, 32'd3);

        applyStimulus(32'hFFFFFFF9, 32'd2, -1, "-7/2");
        checkOutput("-7/2.lo_const", lo, 32'hFFFFFFFD);
        checkOutput("-7/2.hi_const", hi, 32'hFFFFFFFF);
        applyStimulus(32'd7, 32'hFFFFFFFE, -1, "7/-2");
        checkOutput("7/-2.lo_const", lo, 32'hFFFFFFFD);
        checkOutput("7/-2.hi_const", hi, 32'h00000001);
        applyStimulus(32'h80000000, 32'hFFFFFFFF, -1, "min/-1");
        checkOutput("min/-1.lo_const", lo, 32'h80000000);
        checkOutput("min/-1.hi_const", hi, 32'h00000000);
        checkOutput("min/-1.div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);

        // Reset mid-run aborts with no done pulse.
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort.busy", {31'd0, busy}, 32'd0);
        checkOutput("abort.hi", hi, 32'd0);
        checkOutput("abort.lo", lo, 32'd0);
        repeat (40) begin
            checkOutput("abort.no_done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        applyStimulus(32'd100, 32'd7, -1, "100/7");
        checkOutput("100/7.lo_const", lo, 32'd14);
        checkOutput("100/7.hi_const", hi, 32'd2);
        @(negedge clk);

        applyStimulus(32'd100, 32'd7, 5, "ignore");
        checkOutput("ignore.lo_const", lo, 32'd14);
        checkOutput("ignore.hi_const", hi, 32'd2);
        @(negedge clk);
        checkOutput("ignore.idle", {31'd0, busy}, 32'd0);

        // Random operands, launched back-to-back in the done cycle.
        for (int i = 0; i < 24; i++) begin
            rx = $urandom;
            ry = $urandom;
            if (i % 3 == 1) ry = $urandom_range(1, 50);
            if (i % 4 == 2) ry = -$urandom_range(1, 50);
            if (ry == 32'd0) ry = 32'd1;
            applyStimulus(rx, ry, -1, "rand");
        end
        @(negedge clk);
        checkOutput("final.done_pulse", {31'd0, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
